// File: rtl/gerador_status_display.sv
// gerador_status_display: feeds the 7-segment display manager.
// Synchronises and debounces the cabin entry/exit sensors, keeps a saturating 2-bit people
// count with full/empty flags, registers the current floor and alternates the display between
// the floor view and the people view on a fixed period.
module gerador_status_display #(
  parameter int unsigned DEBOUNCE_CICLOS = 4,
  parameter int unsigned PERIODO_DISPLAY = 8,
  parameter int unsigned MAX_PESSOAS     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_entrada,
  input  logic       sensor_saida,
  input  logic [1:0] andar_req,
  input  logic       andar_valido,
  output logic [1:0] andar,
  output logic       A,
  output logic       B,
  output logic       controle_Mux,
  output logic       lotado,
  output logic       vazio
);

  // Debounce counter only needs to reach DEBOUNCE_CICLOS-1: the last differing sample is
  // accepted directly instead of being counted.
  localparam int unsigned DbW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CICLOS - 1);

  localparam int unsigned TmW = (PERIODO_DISPLAY > 1) ? $clog2(PERIODO_DISPLAY) : 1;
  localparam logic [TmW-1:0] TmLast = TmW'(PERIODO_DISPLAY - 1);

  localparam logic [1:0] CntMax = 2'(MAX_PESSOAS);

  // Sensor slot indices inside the per-sensor vectors.
  localparam int unsigned SensEnt = 0;
  localparam int unsigned SensSai = 1;

  typedef enum logic [0:0] {
    StVerAndar   = 1'b0,
    StVerPessoas = 1'b1
  } view_e;

  // ---------------------------------------------------------------------------------------
  // Sensor path
  // ---------------------------------------------------------------------------------------
  logic [1:0]     sensor_raw;
  logic [1:0]     sync1_q;
  logic [1:0]     sync2_q;
  logic [1:0]     level_q;
  logic [1:0]     level_d;
  logic [1:0]     pulse;
  logic [DbW-1:0] db_cnt_q [2];
  logic [DbW-1:0] db_cnt_d [2];

  assign sensor_raw[SensEnt] = sensor_entrada;
  assign sensor_raw[SensSai] = sensor_saida;

  // Two-flop synchroniser for both raw sensors.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sensor_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CICLOS consecutive disagreeing samples.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          level_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q     <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      level_q     <= level_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
    end
  end

  // Event pulse on the accepted rising edge; the count moves on the same edge as the level.
  assign pulse = level_d & ~level_q;

  // ---------------------------------------------------------------------------------------
  // People counter
  // ---------------------------------------------------------------------------------------
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;
  logic       lotado_q;
  logic       lotado_d;
  logic       vazio_q;
  logic       vazio_d;

  // Saturating up/down count; simultaneous entry and exit cancel out.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({pulse[SensEnt], pulse[SensSai]})
      2'b10: begin
        if (cnt_q < CntMax) cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
    lotado_d = (cnt_d == CntMax);
    vazio_d  = (cnt_d == 2'd0);
  end

  // Count and flags, flags computed from the next count so they move together.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= 2'd0;
      lotado_q <= 1'b0;
      vazio_q  <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      lotado_q <= lotado_d;
      vazio_q  <= vazio_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Floor register and display alternation
  // ---------------------------------------------------------------------------------------
  logic [1:0]     andar_q;
  logic [1:0]     andar_d;
  logic           floor_change;
  view_e          state_q;
  view_e          state_d;
  logic [TmW-1:0] timer_q;
  logic [TmW-1:0] timer_d;

  assign floor_change = andar_valido && (andar_req != andar_q);

  // Floor capture; rewriting the same floor is harmless.
  always_comb begin
    andar_d = andar_q;
    if (andar_valido) andar_d = andar_req;
  end

  // View FSM: toggle at the end of each period, a floor change restarts the floor view.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TmW'(1);
    if (floor_change) begin
      state_d = StVerAndar;
      timer_d = '0;
    end else if (timer_q == TmLast) begin
      timer_d = '0;
      unique case (state_q)
        StVerAndar:   state_d = StVerPessoas;
        StVerPessoas: state_d = StVerAndar;
        default:      state_d = StVerAndar;
      endcase
    end
  end

  // Floor, view state and view timer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      andar_q <= 2'd0;
      state_q <= StVerAndar;
      timer_q <= '0;
    end else begin
      andar_q <= andar_d;
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  assign andar        = andar_q;
  assign A            = cnt_q[1];
  assign B            = cnt_q[0];
  assign controle_Mux = (state_q == StVerPessoas);
  assign lotado       = lotado_q;
  assign vazio        = vazio_q;

endmodule

// File: tb/tb_gerador_status_display.sv
// Bench for gerador_status_display: directed scenarios with literal expectations plus a long
// randomized run, all checked every cycle against a behavioural model of the display inputs.
module tb_gerador_status_display;

  localparam int D    = 4;
  localparam int P    = 8;
  localparam int MAXP = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       sensor_entrada;
  logic       sensor_saida;
  logic [1:0] andar_req;
  logic       andar_valido;
  logic [1:0] andar;
  logic       A;
  logic       B;
  logic       controle_Mux;
  logic       lotado;
  logic       vazio;

  always #5 clk = ~clk;

  gerador_status_display #(
    .DEBOUNCE_CICLOS(D),
    .PERIODO_DISPLAY(P),
    .MAX_PESSOAS    (MAXP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sensor_entrada(sensor_entrada),
    .sensor_saida  (sensor_saida),
    .andar_req     (andar_req),
    .andar_valido  (andar_valido),
    .andar         (andar),
    .A             (A),
    .B             (B),
    .controle_Mux  (controle_Mux),
    .lotado        (lotado),
    .vazio         (vazio)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------------------
  // Behavioural model: raw sample history per sensor, level flips when the last D synchronised
  // samples all disagree; view = which period of length P we are in since the last restart.
  // ---------------------------------------------------------------------------------------
  bit         m_valid = 1'b0;
  int         m_cnt;
  logic [1:0] m_andar;
  bit         m_lvl  [2];
  bit         m_hist [2][D+1];  // m_hist[s][i] = raw sampled i+1 edges ago
  int         ecount = 0;
  int         vstart = 0;

  always @(posedge clk) begin
    bit raw [2];
    bit rise [2];
    bit all_diff;
    ecount++;
    raw[0] = sensor_entrada;
    raw[1] = sensor_saida;
    if (reset) begin
      m_valid = 1'b1;
      m_cnt   = 0;
      m_andar = 2'd0;
      vstart  = ecount;
      for (int s = 0; s < 2; s++) begin
        m_lvl[s] = 1'b0;
        for (int j = 0; j <= D; j++) m_hist[s][j] = 1'b0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        // Synchronised sample seen now is the raw value from two edges back (m_hist[s][1]).
        all_diff = 1'b1;
        for (int j = 1; j <= D; j++) if (m_hist[s][j] == m_lvl[s]) all_diff = 1'b0;
        rise[s] = 1'b0;
        if (all_diff) begin
          rise[s]  = !m_lvl[s];
          m_lvl[s] = !m_lvl[s];
        end
        for (int j = D; j >= 1; j--) m_hist[s][j] = m_hist[s][j-1];
        m_hist[s][0] = raw[s];
      end
      if (rise[0] && !rise[1] && m_cnt < MAXP) m_cnt++;
      else if (rise[1] && !rise[0] && m_cnt > 0) m_cnt--;
      if (andar_valido) begin
        if (andar_req != m_andar) vstart = ecount;
        m_andar = andar_req;
      end
    end
  end

  function automatic logic [6:0] model_vec();
    logic [1:0] c;
    logic       mux;
    c   = 2'(m_cnt);
    mux = (((ecount - vstart) / P) % 2) == 1;
    return {m_andar, c, mux, (m_cnt == MAXP), (m_cnt == 0)};
  endfunction

  logic [6:0] dut_vec;
  assign dut_vec = {andar, A, B, controle_Mux, lotado, vazio};

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (m_valid) check("cycle", dut_vec, model_vec());
  end

  // ---------------------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_ab(input string name, input logic [1:0] exp);
    check(name, {5'd0, A, B}, {5'd0, exp});
  endtask

  task automatic entry_event();
    sensor_entrada = 1'b1;
    repeat (8) tick();
    sensor_entrada = 1'b0;
    repeat (8) tick();
  endtask

  task automatic exit_event();
    sensor_saida = 1'b1;
    repeat (8) tick();
    sensor_saida = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    bit seen;
    logic [1:0] exp_in  [4];
    logic [1:0] exp_out [4];
    reset          = 1'b1;
    sensor_entrada = 1'b0;
    sensor_saida   = 1'b0;
    andar_req      = 2'd0;
    andar_valido   = 1'b0;
    tick();
    tick();
    check("reset_state", dut_vec, 7'b00_00_0_0_1);
    reset = 1'b0;

    // 1: idle alternation, toggle at the 8th and 16th edges after release.
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("t1_mux", {6'd0, controle_Mux}, {6'd0, (i >= 8 && i < 16)});
      if (i == 8) check("t1_vec", dut_vec, 7'b00_00_1_0_1);
    end

    // 2: held entry counted once after 6 edges; a 3-cycle glitch is rejected.
    sensor_entrada = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 5) check_ab("t2_before", 2'd0);
      if (i == 6) check_ab("t2_latency", 2'd1);
    end
    sensor_entrada = 1'b0;
    repeat (8) tick();
    check_ab("t2_once", 2'd1);
    sensor_entrada = 1'b1;
    repeat (3) tick();
    sensor_entrada = 1'b0;
    repeat (10) tick();
    check_ab("t2_glitch", 2'd1);

    // 3: saturation both ways with flags.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_in  = '{2'd1, 2'd2, 2'd3, 2'd3};
    exp_out = '{2'd2, 2'd1, 2'd0, 2'd0};
    for (int i = 0; i < 4; i++) begin
      entry_event();
      check_ab("t3_in", exp_in[i]);
      check("t3_lotado", {6'd0, lotado}, {6'd0, (i >= 2)});
    end
    for (int i = 0; i < 4; i++) begin
      exit_event();
      check_ab("t3_out", exp_out[i]);
      check("t3_vazio", {6'd0, vazio}, {6'd0, (i >= 2)});
    end

    // 4: simultaneous entry and exit from count 1.
    entry_event();
    sensor_entrada = 1'b1;
    sensor_saida   = 1'b1;
    repeat (8) tick();
    sensor_entrada = 1'b0;
    sensor_saida   = 1'b0;
    repeat (8) tick();
    check_ab("t4_both", 2'd1);

    // 5: floor change during the people view restarts the floor view.
    seen = 1'b0;
    for (int i = 0; i < 2 * P + 2 && !seen; i++) begin
      tick();
      if (controle_Mux) seen = 1'b1;
    end
    check("t5_wait_view", {6'd0, seen}, 7'd1);
    andar_req    = 2'd2;
    andar_valido = 1'b1;
    tick();
    andar_valido = 1'b0;
    check("t5_change", {andar, controle_Mux, 4'd0}, {2'd2, 1'b0, 4'd0});
    for (int j = 1; j <= P; j++) begin
      tick();
      check("t5_period", {6'd0, controle_Mux}, {6'd0, (j == P)});
    end
    // Same floor again right after the toggle: alternation must not restart.
    andar_valido = 1'b1;
    tick();
    andar_valido = 1'b0;
    for (int j = 2; j <= P; j++) begin
      check("t5_same", {6'd0, controle_Mux}, {6'd0, (j - 1 < P)});
      tick();
    end
    check("t5_same_toggle", {andar, controle_Mux, 4'd0}, {2'd2, 1'b0, 4'd0});

    // 6: reset mid-debounce and mid-view, held sensor counted once after full latency.
    sensor_entrada = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("t6_reset", dut_vec, 7'b00_00_0_0_1);
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 5) check_ab("t6_before", 2'd0);
      if (i == 6) check_ab("t6_latency", 2'd1);
    end
    repeat (10) tick();
    check_ab("t6_once", 2'd1);
    sensor_entrada = 1'b0;
    repeat (8) tick();

    // Randomized run, checked by the per-cycle comparison.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) sensor_entrada = ~sensor_entrada;
      if ($urandom_range(0, 5) == 0) sensor_saida = ~sensor_saida;
      andar_valido = ($urandom_range(0, 9) == 0);
      andar_req    = 2'($urandom_range(0, 3));
      reset        = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset        = 1'b0;
    andar_valido = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
